// File: rtl/manch_decoding.sv
// -----------------------------------------------------------------------------
// manch_decoding
//
// Recovers NRZ data from a Manchester line (line = bitclock XOR data, so the
// first half-bit carries the data level). The line is synchronised and every
// transition is timed with a saturating 16-bit interval counter. A two-state
// FSM (HUNT / LOCKED) separates mid-bit transitions from bit-boundary ones.
//
// HUNT   : every transition restarts the interval count. The first transition
//          that arrives LO..HI cycles after the previous one is taken as
//          mid-bit. That bit is emitted and the FSM moves to LOCKED.
// LOCKED : transitions less than LO cycles after the last mid-bit edge are
//          bit boundaries and are ignored. A transition inside LO..HI is the
//          next mid-bit edge. If the count reaches HI+1 first, lock is lost.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx_manch   in   Manchester line, asynchronous to clk
//   rx_data    out  last decoded bit, held until the next one
//   rx_valid   out  one-cycle strobe, rx_data is new in the same cycle
//   rx_locked  out  high while the FSM is LOCKED
//   rx_err     out  one-cycle strobe on loss of lock
//
// Output handshake: rx_valid is a pure strobe with no ready/back-pressure.
// A consumer must take rx_data in the cycle rx_valid is high. rx_data keeps
// its value afterwards, but only the strobe marks a new bit. rx_err is never
// high in the same cycle as rx_valid.
// -----------------------------------------------------------------------------
module manch_decoding #(
  parameter int BAUDRATE = 115200 * 2,
  parameter int CLK_FREQ = 18_750_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_manch,
  output logic rx_data,
  output logic rx_valid,
  output logic rx_locked,
  output logic rx_err
);

  // Nominal half-bit length and the mid-bit acceptance window, in clk cycles.
  localparam int HALF = CLK_FREQ / BAUDRATE;
  localparam int LO_I = (3 * HALF) / 2;
  localparam int HI_I = (5 * HALF) / 2;

  localparam logic [15:0] LO      = 16'(LO_I);
  localparam logic [15:0] HI      = 16'(HI_I);
  localparam logic [15:0] TMO     = 16'(HI_I + 1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  if (HALF < 4 || HI_I > 65535) begin : g_param_check
    $error("manch_decoding: HALF must be >= 4 and HI must fit in 16 bits");
  end

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t      state;
  logic        s1;
  logic        s2;
  logic        s3;
  logic [15:0] cnt;

  logic line_edge;
  logic in_window;
  logic timeout;

  // s1/s2 synchronise the line. s3 holds the previous synchronised level, so
  // s3 is the pre-edge level, which is the decoded bit for a mid-bit edge.
  assign line_edge = s2 ^ s3;
  assign in_window = (cnt >= LO) && (cnt <= HI);
  // An edge only qualifies while cnt <= HI, so it can never coincide with
  // the timeout, and the timeout branch can safely take priority.
  assign timeout   = (state == LOCKED) && (cnt == TMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      state     <= HUNT;
      rx_data   <= 1'b0;
      rx_valid  <= 1'b0;
      rx_locked <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      s1       <= rx_manch;
      s2       <= s1;
      s3       <= s2;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;

      // Free-running interval count. The branches below override it with a
      // clear when an edge is accepted or when lock is lost.
      if (cnt != CNT_MAX) begin
        cnt <= cnt + 16'd1;
      end

      case (state)
        HUNT: begin
          if (line_edge) begin
            cnt <= '0;
            if (in_window) begin
              state     <= LOCKED;
              rx_locked <= 1'b1;
              rx_data   <= s3;
              rx_valid  <= 1'b1;
            end
          end
        end

        LOCKED: begin
          if (timeout) begin
            state     <= HUNT;
            rx_locked <= 1'b0;
            rx_err    <= 1'b1;
            cnt       <= '0;
          end else if (line_edge && in_window) begin
            cnt      <= '0;
            rx_data  <= s3;
            rx_valid <= 1'b1;
          end
          // Edges with cnt < LO are bit boundaries. They leave cnt running.
        end

        default: begin
          state <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_manch_decoding.sv
// -----------------------------------------------------------------------------
// tb_manch_decoding
//
// The line is built as a series of constant-level segments, each a whole
// number of clk cycles long, and every line change is logged. Each run starts
// from reset. At the end of a run, an event-level reference model turns the
// change log into a list of expected strobes. Each strobe records its cycle,
// its kind, rx_data and rx_locked. That list is compared against the strobes
// the monitor collected from the DUT.
//
// Timing used by the model:
// - A line change made during cycle n is seen as an edge in cycle n+2.
// - The resulting rx_valid strobe is visible in cycle n+3.
// - The interval count in cycle c is c - (cycle of last clear) - 1.
// -----------------------------------------------------------------------------
module tb_manch_decoding;

  // Nominal timing at the default parameters.
  localparam int HALF = 81;
  localparam int LO   = 121;
  localparam int HI   = 202;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx_manch = 1'b0;
  logic rx_data;
  logic rx_valid;
  logic rx_locked;
  logic rx_err;

  manch_decoding dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_manch (rx_manch),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_locked(rx_locked),
    .rx_err   (rx_err)
  );

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  // Cycle index since the last reset release. Cycle 0 runs from the release
  // up to the first rising edge.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard
  // Event word: {cycle[31:0], err, valid, rx_data, rx_locked}
  logic [35:0] exp_q[$];
  logic [35:0] act_q[$];
  int          chg_cyc[$];
  bit          chg_lvl[$];
  bit          bits_q[$];
  bit          want_q[$];
  bit          mon_en = 1'b0;
  string       run_name = "init";
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) begin
    #1;
    if (mon_en && (rx_valid || rx_err))
      act_q.push_back({32'(cyc), rx_err, rx_valid, rx_data, rx_locked});
  end

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL [%s] %s: got %0d, expected %0d", run_name, name, got, want);
    end
  endtask

  task automatic check_ev(input int i, input logic [35:0] got, input logic [35:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL [%s] event[%0d]: got cyc=%0d err=%0b valid=%0b data=%0b locked=%0b, expected cyc=%0d err=%0b valid=%0b data=%0b locked=%0b",
               run_name, i, got[35:4], got[3], got[2], got[1], got[0],
               want[35:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  // Reference model. It walks the logged line changes as timed events and
  // applies the decoding rules. Results are written to exp_q, keeping only
  // events at or before end_cyc.
  task automatic build_expected(input int end_cyc);
    int          last_clear;
    int          d;
    int          gap;
    int          t;
    bit          locked;
    bit          last_bit;
    bit          prev_lvl;
    bit          pre;
    logic [35:0] all_q[$];
    last_clear = -1;
    locked     = 1'b0;
    last_bit   = 1'b0;
    prev_lvl   = 1'b0;
    exp_q.delete();
    for (int i = 0; i < chg_cyc.size(); i++) begin
      d        = chg_cyc[i] + 2;
      pre      = prev_lvl;
      prev_lvl = chg_lvl[i];
      t        = last_clear + HI + 2;   // cycle in which the count hits HI+1
      if (locked && d >= t) begin
        all_q.push_back({32'(t + 1), 2'b10, last_bit, 1'b0});
        locked     = 1'b0;
        last_clear = t;
        if (d == t) continue;           // edge lost to the timeout
      end
      gap = d - last_clear - 1;
      if (!locked) begin
        last_clear = d;
        if (gap >= LO && gap <= HI) begin
          locked   = 1'b1;
          last_bit = pre;
          all_q.push_back({32'(d + 1), 2'b01, pre, 1'b1});
        end
      end else if (gap >= LO) begin
        last_clear = d;
        last_bit   = pre;
        all_q.push_back({32'(d + 1), 2'b01, pre, 1'b1});
      end
    end
    if (locked)
      all_q.push_back({32'(last_clear + HI + 3), 2'b10, last_bit, 1'b0});
    foreach (all_q[k])
      if (int'(all_q[k][35:4]) <= end_cyc) exp_q.push_back(all_q[k]);
  endtask

  // ---------------------------------------------------------------- drivers
  // Called at a falling edge, or at start-up. Holds reset for 3 clocks and
  // starts a fresh run with the line resting at idle.
  task automatic start_run(input bit idle);
    mon_en   = 1'b0;
    rx_manch = idle;
    rst_n    = 1'b0;
    #1;
    check("reset rx_valid",  rx_valid,  0);
    check("reset rx_err",    rx_err,    0);
    check("reset rx_locked", rx_locked, 0);
    check("reset rx_data",   rx_data,   0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chg_cyc.delete();
    chg_lvl.delete();
    act_q.delete();
    // The synchroniser leaves reset at 0, so an idle-high line is a change.
    if (idle) begin
      chg_cyc.push_back(0);
      chg_lvl.push_back(1'b1);
    end
    mon_en = 1'b1;
  endtask

  task automatic seg(input bit lvl, input int dur);
    if (lvl != rx_manch) begin
      rx_manch = lvl;
      chg_cyc.push_back(cyc);
      chg_lvl.push_back(lvl);
    end
    repeat (dur) @(negedge clk);
  endtask

  // Sends bits_q. The first half-bit is the data level. Each half-bit length
  // is drawn from its own range.
  task automatic send_bits(input int a_lo, input int a_hi, input int b_lo, input int b_hi);
    foreach (bits_q[i]) begin
      seg(bits_q[i],  int'($urandom_range(a_hi, a_lo)));
      seg(!bits_q[i], int'($urandom_range(b_hi, b_lo)));
    end
  endtask

  task automatic finish_run(input int tail);
    repeat (tail) @(negedge clk);
    mon_en = 1'b0;
    build_expected(cyc);
    check("event count", act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      check_ev(i, act_q[i], exp_q[i]);
  endtask

  // Compares the decoded bits of the finished run against want_q.
  task automatic check_data();
    bit got_q[$];
    foreach (act_q[k]) if (act_q[k][2]) got_q.push_back(act_q[k][1]);
    check("decoded bit count", got_q.size(), want_q.size());
    for (int i = 0; i < got_q.size() && i < want_q.size(); i++)
      check($sformatf("decoded bit %0d", i), got_q[i], want_q[i]);
  endtask

  task automatic count_err(output int ne);
    ne = 0;
    foreach (act_q[k]) if (act_q[k][3]) ne++;
  endtask

  // ---------------------------------------------------------------- vectors
  // Lock first, then a single interval w after the locking edge. Each record
  // gives the number of decoded bits expected, and the delay from the first
  // rx_valid to the single rx_err strobe.
  typedef struct {
    int w;
    int n_valid;
    int err_delay;
  } win_vec_t;

  win_vec_t win_tab[6];
  int       nv;
  int       ne;
  int       v0;
  int       e0;
  int       d2;

  initial begin
    win_tab = '{'{81, 1, 204}, '{121, 1, 204}, '{122, 2, 326},
                '{162, 2, 366}, '{203, 2, 407}, '{204, 1, 204}};
    #2;

    // Constant line, idle low: no strobes at all.
    run_name = "constant low";
    start_run(1'b0);
    seg(1'b0, 2000);
    finish_run(0);
    check("constant low strobes", act_q.size(), 0);

    // Idle-high line gives one spurious synchroniser edge, which is discarded.
    run_name = "constant high";
    start_run(1'b1);
    seg(1'b1, 2000);
    finish_run(0);
    check("constant high strobes", act_q.size(), 0);

    // Window table.
    for (int i = 0; i < 6; i++) begin
      run_name = $sformatf("window w=%0d", win_tab[i].w);
      start_run(1'b1);
      seg(1'b1, 300);
      seg(1'b0, 162);
      seg(1'b1, win_tab[i].w);
      seg(1'b0, 300);
      finish_run(10);
      nv = 0; ne = 0; v0 = 0; e0 = 0; d2 = 0;
      foreach (act_q[k]) begin
        if (act_q[k][2]) begin
          if (nv == 0) v0 = int'(act_q[k][35:4]);
          else         d2 = int'(act_q[k][1]);
          nv++;
        end
        if (act_q[k][3]) begin
          ne++;
          e0 = int'(act_q[k][35:4]);
        end
      end
      check("valid count", nv, win_tab[i].n_valid);
      check("err count", ne, 1);
      check("err delay", e0 - v0, win_tab[i].err_delay);
      if (win_tab[i].n_valid == 2) check("second bit", d2, 1);
    end

    // Nominal stream 1,1,0,1,0,0: locks on bit 3, then one strobe per 162 clk.
    run_name = "nominal 110100";
    start_run(1'b0);
    seg(1'b0, 20);
    bits_q = '{1, 1, 0, 1, 0, 0};
    send_bits(HALF, HALF, HALF, HALF);
    finish_run(300);
    want_q = '{0, 1, 0, 0};
    check_data();
    v0 = -1;
    foreach (act_q[k]) if (act_q[k][2]) begin
      if (v0 >= 0) check("valid spacing", int'(act_q[k][35:4]) - v0, 2 * HALF);
      v0 = int'(act_q[k][35:4]);
    end

    // Alternating 0,1,... : long pulses only. Locks on the second bit.
    run_name = "alternating";
    start_run(1'b1);
    seg(1'b1, 50);
    bits_q = '{0, 1, 0, 1, 0, 1, 0, 1};
    send_bits(HALF, HALF, HALF, HALF);
    finish_run(300);
    want_q = '{1, 0, 1, 0, 1, 0, 1};
    check_data();

    // All ones never locks. A single 0 then locks immediately.
    run_name = "all ones then zero";
    start_run(1'b0);
    seg(1'b0, 30);
    bits_q = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    send_bits(HALF, HALF, HALF, HALF);
    check("strobes during all ones", act_q.size(), 0);
    bits_q = '{0, 1, 1, 1, 1};
    send_bits(HALF, HALF, HALF, HALF);
    finish_run(300);
    want_q = '{0, 1, 1, 1, 1};
    check_data();

    // Stretched (200 clk) and shrunk (124 clk) bit periods still decode.
    for (int h = 0; h < 2; h++) begin
      run_name = (h == 0) ? "period 200" : "period 124";
      start_run(1'b0);
      seg(1'b0, 40);
      bits_q = '{1, 0, 0, 1, 1, 0, 1, 0};
      if (h == 0) send_bits(100, 100, 100, 100);
      else        send_bits(62, 62, 62, 62);
      finish_run(300);
      want_q = '{0, 0, 1, 1, 0, 1, 0};
      check_data();
    end

    // Locked at nominal timing, then the period grows to 205 clk: lock is lost.
    run_name = "period 205";
    start_run(1'b0);
    seg(1'b0, 40);
    bits_q = '{1, 0, 1, 0};
    send_bits(HALF, HALF, HALF, HALF);
    bits_q = '{1, 1, 1};
    send_bits(103, 103, 102, 102);
    finish_run(300);
    want_q = '{0, 1, 0, 1};
    check_data();
    count_err(ne);
    check("period 205 err count", ne, 1);

    // Reset in the middle of a locked bit, then relock on the following stream.
    run_name = "mid-lock reset";
    start_run(1'b0);
    seg(1'b0, 20);
    bits_q = '{1, 0, 1, 0, 1};
    send_bits(HALF, HALF, HALF, HALF);
    seg(rx_manch, 40);
    check("locked before reset", rx_locked, 1);
    finish_run(0);
    run_name = "after mid-lock reset";
    start_run(rx_manch);
    seg(rx_manch, 30);
    bits_q = '{0, 1, 0, 1};
    send_bits(HALF, HALF, HALF, HALF);
    finish_run(300);
    want_q = '{1, 0, 1};
    check_data();

    // Random streams: jittered half-bits, occasional long holds, and some runs
    // cut short by a reset.
    for (int r = 0; r < 8; r++) begin
      bit idle;
      idle = bit'($urandom_range(1, 0));
      run_name = $sformatf("random %0d", r);
      start_run(idle);
      seg(idle, int'($urandom_range(300, 5)));
      for (int k = 0; k < 12; k++) begin
        bit b;
        b = bit'($urandom_range(1, 0));
        if ($urandom_range(7, 0) == 0) seg(rx_manch, int'($urandom_range(260, 120)));
        seg(b,  int'($urandom_range(100, 62)));
        seg(!b, int'($urandom_range(100, 62)));
      end
      if (r % 3 == 2) finish_run(int'($urandom_range(20, 0)));
      else            finish_run(300);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
